source_read16: RTL and testbench
================================

SOURCE_READ16 -- requirements
Module: source_read16

Interface
REQ-001 The block SHALL expose the following ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to begin a read burst; sampled only in IDLE
- start_addr  in  3  first register index of the burst
- length  in  4  number of words to read; 0 = empty burst; 9..15 clamped to 8
- reg_0 .. reg_7  in  16 each  register-file contents to be read
- rdata  out  16  word currently offered
- raddr  out  3  index of the word in rdata
- rvalid  out  1  rdata/raddr/last are valid
- rready  in  1  consumer accepts the word when rvalid=1
- last  out  1  offered word is the final word of the burst
- busy  out  1  burst in progress; high in SEND and DONE
- done  out  1  one-cycle pulse at end of every accepted burst
REQ-002 The block SHALL use one clock, clk, and a synchronous active-high reset, rst; there SHALL be no other clock or asynchronous input.
REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The block SHALL implement an FSM with states IDLE, SEND and DONE.
REQ-005 In IDLE with start=1 and effective length L>=1, at that edge:
- SEND is entered.
- rdata <= reg[start_addr] and raddr <= start_addr.
- rvalid <= 1; last <= (L==1); busy <= 1.
- Remaining count is set to L.
REQ-006 In IDLE with start=1 and length=0, at that edge:
- DONE is entered with busy <= 1.
- No word is offered; rvalid stays 0.
REQ-007 Latency: the first word SHALL be valid in the cycle immediately after the edge that sampled start.
REQ-008 A transfer SHALL occur at an edge where rvalid=1 and rready=1. No other condition consumes a word.
REQ-009 On a transfer with remaining>1, at that edge:
- raddr <= raddr+1, wrapping 7 -> 0.
- rdata <= reg[raddr+1 mod 8], sampled at that edge.
- remaining decrements by 1.
- last <= (remaining==2).
- rvalid stays 1, so back-to-back transfers run at one word per cycle.
REQ-010 On a transfer with remaining==1, at that edge:
- DONE is entered.
- rvalid <= 0 and last <= 0.
REQ-011 While rvalid=1 and rready=0, rdata, raddr and last SHALL hold their values even if any reg_x input changes.
REQ-012 In DONE, done SHALL be 1 for exactly one cycle. At the next edge the FSM returns to IDLE, and done and busy go to 0.
REQ-013 start SHALL be ignored in SEND and DONE. A new burst can begin no earlier than the first IDLE cycle.
REQ-014 A burst with L=8 SHALL read every register exactly once, in ascending index order modulo 8 starting at start_addr.
REQ-015 rready SHALL have no effect while rvalid=0.

Reset
REQ-016 When rst=1 at an edge, the block SHALL enter IDLE and clear: rdata=0, raddr=0, rvalid=0, last=0, busy=0, done=0, remaining count=0.
REQ-017 rst SHALL override start and any pending transfer in the same cycle. A burst interrupted by reset SHALL NOT complete and SHALL NOT pulse done.
REQ-018 The block SHALL not be sensitive to start during the reset cycle; the first start honoured is one sampled with rst=0.

Verification
REQ-019 Basic burst:
- Stimulus: reg_k = 16'h1000+k; start with start_addr=2, length=3; rready=1 throughout.
- Required response: rvalid for 3 consecutive cycles with (raddr, rdata) = (2, 1002), (3, 1003), (4, 1004); last only on the third word; done pulses the cycle after the third word.
REQ-020 Wrap-around:
- Stimulus: start_addr=6, length=4.
- Required response: raddr sequence 6, 7, 0, 1 with matching rdata.
REQ-021 Backpressure:
- Stimulus: rready=0 for 3 cycles on word 2; change reg_3 during the stall.
- Required response: rdata holds its captured value throughout the stall; the updated reg_3 value is not seen in the stalled word.
REQ-022 Length edge cases:
- Stimulus: length=0, then length=12.
- Required response: length=0 gives no rvalid and done 1 cycle after start; length=12 gives exactly 8 words.
REQ-023 Reset and busy behaviour:
- Stimulus: rst asserted mid-burst after 2 words; separately, start pulsed while busy=1.
- Required response: reset returns all outputs to 0 the next cycle with no done; start while busy is ignored and the burst is unchanged.

Source files
------------

// File: rtl/source_read16.sv
// rtl/source_read16.sv - register-file burst reader with valid/ready handshake
//
// Purpose: on a start request in IDLE, offers a burst of up to 8 words from
// the eight 16-bit register inputs, starting at start_addr and ascending
// modulo 8, one word per rvalid/rready transfer, then pulses done.
//
// Ports:
//   clk              rising-edge clock for all state
//   rst              synchronous active-high reset
//   start            burst request, sampled only in IDLE
//   start_addr[2:0]  first register index of the burst
//   length[3:0]      word count; 0 = empty burst, 9..15 treated as 8
//   reg_0..reg_7     register-file contents (16 bits each)
//   rdata[15:0]      word currently offered
//   raddr[2:0]       index of the offered word
//   rvalid           rdata/raddr/last are valid
//   rready           consumer accepts the offered word
//   last             offered word is the final word of the burst
//   busy             burst in progress (SEND and DONE)
//   done             one-cycle pulse at the end of each burst

module source_read16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  start_addr,
    input  logic [3:0]  length,
    input  logic [15:0] reg_0,
    input  logic [15:0] reg_1,
    input  logic [15:0] reg_2,
    input  logic [15:0] reg_3,
    input  logic [15:0] reg_4,
    input  logic [15:0] reg_5,
    input  logic [15:0] reg_6,
    input  logic [15:0] reg_7,
    output logic [15:0] rdata,
    output logic [2:0]  raddr,
    output logic        rvalid,
    input  logic        rready,
    output logic        last,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  raddr_q, raddr_d;
    logic        rvalid_q, rvalid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  rem_q, rem_d;

    logic [15:0] regs [8];
    logic [3:0]  eff_len;
    logic [2:0]  next_addr;

    assign regs[0] = reg_0;
    assign regs[1] = reg_1;
    assign regs[2] = reg_2;
    assign regs[3] = reg_3;
    assign regs[4] = reg_4;
    assign regs[5] = reg_5;
    assign regs[6] = reg_6;
    assign regs[7] = reg_7;

    // Anything longer than the register file reads each register once.
    assign eff_len   = (length > 4'd8) ? 4'd8 : length;
    // 3-bit add wraps 7 -> 0 on its own.
    assign next_addr = raddr_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        rdata_d  = rdata_q;
        raddr_d  = raddr_q;
        rvalid_d = rvalid_q;
        last_d   = last_q;
        busy_d   = busy_q;
        done_d   = done_q;
        rem_d    = rem_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (eff_len == 4'd0) begin
                        // Empty burst: skip straight to the done pulse.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = S_SEND;
                        rdata_d  = regs[start_addr];
                        raddr_d  = start_addr;
                        rvalid_d = 1'b1;
                        last_d   = (eff_len == 4'd1);
                        rem_d    = eff_len;
                    end
                end
            end
            S_SEND: begin
                if (rvalid_q && rready) begin
                    if (rem_q > 4'd1) begin
                        // Next word is captured here, so a stalled word is
                        // immune to later register changes.
                        raddr_d = next_addr;
                        rdata_d = regs[next_addr];
                        rem_d   = rem_q - 4'd1;
                        last_d  = (rem_q == 4'd2);
                    end else begin
                        state_d  = S_DONE;
                        rvalid_d = 1'b0;
                        last_d   = 1'b0;
                        rem_d    = 4'd0;
                        done_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rdata_q  <= 16'd0;
            raddr_q  <= 3'd0;
            rvalid_q <= 1'b0;
            last_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rem_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            rdata_q  <= rdata_d;
            raddr_q  <= raddr_d;
            rvalid_q <= rvalid_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rem_q    <= rem_d;
        end
    end

    assign rdata  = rdata_q;
    assign raddr  = raddr_q;
    assign rvalid = rvalid_q;
    assign last   = last_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_source_read16.sv
// tb/tb_source_read16.sv - self-checking bench for source_read16
module tb_source_read16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  start_addr;
    logic [3:0]  length;
    logic [15:0] regs [8];
    logic [15:0] rdata;
    logic [2:0]  raddr;
    logic        rvalid;
    logic        rready;
    logic        last;
    logic        busy;
    logic        done;

    int checks = 0;
    int failures = 0;

    source_read16 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .reg_0      (regs[0]),
        .reg_1      (regs[1]),
        .reg_2      (regs[2]),
        .reg_3      (regs[3]),
        .reg_4      (regs[4]),
        .reg_5      (regs[5]),
        .reg_6      (regs[6]),
        .reg_7      (regs[7]),
        .rdata      (rdata),
        .raddr      (raddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .last       (last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sa;
        logic [3:0] len;
        int         exp_words;
        logic [2:0] exp_last_addr;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: word i of a burst is register (sa+i) mod 8, effective length
    // is min(len,8); done follows the final accepted word by one cycle.
    task automatic run_burst(input logic [2:0] sa, input logic [3:0] len, input bit rnd,
                             input string nm, output int got, output logic [2:0] lastaddr);
        int   L;
        int   cyc;
        bit   fin;
        logic [2:0] a;
        L = (len > 4'd8) ? 8 : int'(len);
        got = 0;
        cyc = 0;
        fin = 0;
        lastaddr = 3'd0;
        start = 1'b1;
        start_addr = sa;
        length = len;
        step();
        start = 1'b0;
        chk({nm, " first_rvalid"}, {31'd0, rvalid}, {31'd0, (L != 0)});
        chk({nm, " busy_after_start"}, {31'd0, busy}, 32'd1);
        while (!fin && cyc < 200) begin
            rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) begin
                chk({nm, " words_at_done"}, got, L);
                chk({nm, " rvalid_at_done"}, {31'd0, rvalid}, 32'd0);
                chk({nm, " busy_at_done"}, {31'd0, busy}, 32'd1);
                fin = 1;
            end else begin
                if (rvalid) begin
                    a = 3'((int'(sa) + got) % 8);
                    chk({nm, " raddr"}, {29'd0, raddr}, {29'd0, a});
                    chk({nm, " rdata"}, {16'd0, rdata}, {16'd0, regs[a]});
                    chk({nm, " last"}, {31'd0, last}, {31'd0, (got == L - 1)});
                    if (rready) begin
                        got++;
                        lastaddr = raddr;
                    end
                end
                step();
                cyc++;
            end
        end
        if (!fin) begin
            failures++;
            checks++;
            $display("FAIL %s timeout: got no done, expected done within 200 cycles", nm);
        end
        rready = 1'b1;
        step();
        chk({nm, " done_cleared"}, {31'd0, done}, 32'd0);
        chk({nm, " busy_cleared"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         got;
        logic [2:0] la;
        int         cyc;
        int         dones;

        vecs[0] = '{sa: 3'd2, len: 4'd3,  exp_words: 3, exp_last_addr: 3'd4};
        vecs[1] = '{sa: 3'd6, len: 4'd4,  exp_words: 4, exp_last_addr: 3'd1};
        vecs[2] = '{sa: 3'd0, len: 4'd0,  exp_words: 0, exp_last_addr: 3'd0};
        vecs[3] = '{sa: 3'd3, len: 4'd12, exp_words: 8, exp_last_addr: 3'd2};
        vecs[4] = '{sa: 3'd7, len: 4'd1,  exp_words: 1, exp_last_addr: 3'd7};
        vecs[5] = '{sa: 3'd0, len: 4'd8,  exp_words: 8, exp_last_addr: 3'd7};
        vecs[6] = '{sa: 3'd5, len: 4'd9,  exp_words: 8, exp_last_addr: 3'd4};
        vecs[7] = '{sa: 3'd1, len: 4'd15, exp_words: 8, exp_last_addr: 3'd0};

        for (int k = 0; k < 8; k++) regs[k] = 16'h1000 + 16'(k);
        rst = 1'b1;
        start = 1'b0;
        start_addr = 3'd0;
        length = 4'd0;
        rready = 1'b1;
        step();
        // start during reset must not be honoured
        start = 1'b1;
        length = 4'd3;
        step();
        start = 1'b0;
        rst = 1'b0;
        chk("reset rdata", {16'd0, rdata}, 32'd0);
        chk("reset raddr", {29'd0, raddr}, 32'd0);
        chk("reset rvalid", {31'd0, rvalid}, 32'd0);
        chk("reset last", {31'd0, last}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        step();
        chk("idle after reset start", {31'd0, busy}, 32'd0);

        // Table-driven bursts with rready held high
        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].sa, vecs[i].len, 1'b0, $sformatf("vec%0d", i), got, la);
            chk($sformatf("vec%0d word_count", i), got, vecs[i].exp_words);
            if (vecs[i].exp_words > 0)
                chk($sformatf("vec%0d last_addr", i), {29'd0, la}, {29'd0, vecs[i].exp_last_addr});
        end

        // Backpressure: stall word 2 (raddr 3) and change reg_3 meanwhile
        start = 1'b1;
        start_addr = 3'd2;
        length = 4'd3;
        rready = 1'b1;
        step();
        start = 1'b0;
        chk("bp w1 raddr", {29'd0, raddr}, 32'd2);
        step();
        rready = 1'b0;
        chk("bp w2 raddr", {29'd0, raddr}, 32'd3);
        for (int c = 0; c < 3; c++) begin
            regs[3] = 16'hBEEF;
            step();
            chk("bp stall rdata", {16'd0, rdata}, 32'h1003);
            chk("bp stall raddr", {29'd0, raddr}, 32'd3);
            chk("bp stall last", {31'd0, last}, 32'd0);
        end
        rready = 1'b1;
        step();
        chk("bp w3 raddr", {29'd0, raddr}, 32'd4);
        chk("bp w3 rdata", {16'd0, rdata}, 32'h1004);
        chk("bp w3 last", {31'd0, last}, 32'd1);
        step();
        chk("bp done", {31'd0, done}, 32'd1);
        step();
        regs[3] = 16'h1003;

        // Reset mid-burst after two words: no done afterwards
        start = 1'b1;
        start_addr = 3'd0;
        length = 4'd6;
        rready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("rst pre raddr", {29'd0, raddr}, 32'd2);
        rst = 1'b1;
        start = 1'b1;
        step();
        rst = 1'b0;
        start = 1'b0;
        chk("rst mid rdata", {16'd0, rdata}, 32'd0);
        chk("rst mid raddr", {29'd0, raddr}, 32'd0);
        chk("rst mid rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst mid last", {31'd0, last}, 32'd0);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            if (done || rvalid) dones++;
            step();
        end
        chk("rst mid no_done", dones, 0);

        // start held high through SEND and DONE must not disturb the burst
        start = 1'b1;
        start_addr = 3'd5;
        length = 4'd3;
        step();
        start_addr = 3'd0;
        length = 4'd1;
        cyc = 0;
        got = 0;
        while (!done && cyc < 20) begin
            if (rvalid) begin
                chk("busy start raddr", {29'd0, raddr}, {29'd0, 3'(5 + got)});
                chk("busy start rdata", {16'd0, rdata}, {16'd0, regs[3'(5 + got)]});
                got++;
            end
            step();
            cyc++;
        end
        chk("busy start words", got, 3);
        chk("busy start done", {31'd0, done}, 32'd1);
        step();
        start = 1'b0;
        chk("busy start idle rvalid", {31'd0, rvalid}, 32'd0);
        chk("busy start idle busy", {31'd0, busy}, 32'd0);
        step();

        // Randomised bursts with random registers and random backpressure
        for (int n = 0; n < 40; n++) begin
            logic [2:0] rsa;
            logic [3:0] rlen;
            int         rl;
            for (int k = 0; k < 8; k++) regs[k] = 16'($urandom);
            rsa  = 3'($urandom_range(0, 7));
            rlen = 4'($urandom_range(0, 15));
            rl   = (rlen > 4'd8) ? 8 : int'(rlen);
            run_burst(rsa, rlen, 1'b1, $sformatf("rnd%0d", n), got, la);
            chk($sformatf("rnd%0d count", n), got, rl);
            for (int c = 0; c < int'($urandom_range(0, 2)); c++) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
